decoder_nto2n_seq: RTL and testbench

- Parametrised, registered successor to the team's 3-to-8 one-hot decoder.
- Accepts a binary select over a valid/ready handshake and drives a registered one-hot output for a programmable number of cycles.
- Flags selects outside the output range.
- Sits between control FSMs and banks of enables (chip selects, lane enables, mux strobes) that need a timed, glitch-free strobe.

---
 rtl/decoder_nto2n_seq.sv | 110 +++++++++++
 tb/tb_decoder_nto2n_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
// decoder_nto2n_seq: registered N-to-2^N decoder driving a timed strobe.
// Define DEC_THERMO_EN to add the therm_mode input (thermometer output).
module decoder_nto2n_seq #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 8,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_sel,
    input  logic [HOLD_W-1:0] in_hold,
`ifdef DEC_THERMO_EN
    input  logic              therm_mode,
`endif
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_onehot,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state, state_n;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic [OUT_W-1:0]  out_n, dec;
    logic              err_n;
    logic              accept;
    logic              in_range;
    logic              therm;
    logic [31:0]       sel_ext;

`ifdef DEC_THERMO_EN
    assign therm = therm_mode;
`else
    assign therm = 1'b0;
`endif

    assign sel_ext   = 32'(in_sel);
    assign in_range  = sel_ext < 32'(OUT_W);
    assign in_ready  = (state == IDLE) || (cnt == '0);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ACTIVE);
    assign busy      = (state == ACTIVE);

    always_comb begin
        dec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dec[i] = therm ? (sel_ext >= 32'(i)) : (sel_ext == 32'(i));
        end
    end

    // The final strobe cycle accepts, so a valid reload has no zero gap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out_onehot;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                out_n = '0;
                if (accept) begin
                    if (in_range) begin
                        out_n   = dec;
                        cnt_n   = in_hold;
                        state_n = ACTIVE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (accept && in_range) begin
                    out_n = dec;
                    cnt_n = in_hold;
                end else begin
                    err_n   = accept;
                    out_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                out_n   = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            out_onehot <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            out_onehot <= out_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// tb_decoder_nto2n_seq: directed and random checks of decoder_nto2n_seq
// against a cycles-remaining reference model; second instance has OUT_W=6.
module tb_decoder_nto2n_seq;

    localparam int OUT_W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_sel;
    logic [3:0] in_hold;
    logic       therm_mode;
    logic       in_ready, out_valid, busy, err;
    logic [7:0] out_onehot;

    logic       v6;
    logic [2:0] s6;
    logic [3:0] h6;
    logic       r6, ov6, b6, e6;
    logic [5:0] o6;

    int         m_left;
    logic [7:0] m_val;
    logic       m_err;
    int         vectors = 0;
    int         errors = 0;
    logic [11:0] act, exp_v;

    always #5 clk = ~clk;

    decoder_nto2n_seq #(.IN_W(3), .OUT_W(8), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_hold(in_hold),
`ifdef DEC_THERMO_EN
        .therm_mode(therm_mode),
`endif
        .out_valid(out_valid), .out_onehot(out_onehot),
        .busy(busy), .err(err)
    );

    decoder_nto2n_seq #(.IN_W(3), .OUT_W(6), .HOLD_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v6), .in_ready(r6),
        .in_sel(s6), .in_hold(h6),
`ifdef DEC_THERMO_EN
        .therm_mode(1'b0),
`endif
        .out_valid(ov6), .out_onehot(o6),
        .busy(b6), .err(e6)
    );

    function automatic logic [7:0] ref_dec(int sel, bit th);
        if (sel >= OUT_W) return 8'h00;
        if (th) return 8'((1 << (sel + 1)) - 1);
        return 8'(1 << sel);
    endfunction

    // Model: m_left = strobe cycles still to show, 0 when idle.
    task automatic tick();
        bit rdy, acc;
        rdy = (m_left <= 1);
        acc = in_valid && rdy;
        @(posedge clk);
        if (!rst_n) begin
            m_left = 0; m_val = 0; m_err = 0;
        end else if (acc && int'(in_sel) < OUT_W) begin
            m_val  = ref_dec(int'(in_sel), therm_mode);
            m_left = int'(in_hold) + 1;
            m_err  = 0;
        end else if (acc) begin
            m_val = 0; m_left = 0; m_err = 1;
        end else begin
            m_err = 0;
            if (m_left > 0) m_left--;
            if (m_left == 0) m_val = 0;
        end
        #1;
        act   = {in_ready, out_valid, busy, err, out_onehot};
        exp_v = {m_left <= 1, m_left > 0, m_left > 0, m_err, m_val};
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; in_sel = 0; in_hold = 0;
        tick(); tick();
        vectors++;
        if (act !== exp_v || act !== 12'h800) begin
            errors++;
            $display("FAIL reset act=%h exp=%h", act, exp_v);
        end
        rst_n = 1;
        tick();
        vectors++;
        if (act !== 12'h800) begin
            errors++;
            $display("FAIL reset_idle act=%h exp=800", act);
        end
    endtask

    task automatic test_single();
        in_valid = 1; in_sel = 5; in_hold = 0;
        tick();
        in_valid = 0;
        vectors++;
        if (act !== exp_v || out_onehot !== 8'h20 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single act=%h exp=%h", act, exp_v);
        end
        tick();
        vectors++;
        if (act !== exp_v || act !== 12'h800) begin
            errors++;
            $display("FAIL single_end act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_hold();
        in_valid = 1; in_sel = 2; in_hold = 3;
        for (int k = 0; k < 4; k++) begin
            tick();
            in_valid = 0; in_hold = 4'hF;
            vectors++;
            if (act !== exp_v || out_onehot !== 8'h04 || in_ready !== (k == 3)) begin
                errors++;
                $display("FAIL hold[%0d] act=%h exp=%h", k, act, exp_v);
            end
        end
        tick();
        vectors++;
        if (act !== exp_v || out_onehot !== 8'h00) begin
            errors++;
            $display("FAIL hold_end act=%h exp=%h", act, exp_v);
        end
        in_hold = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h02; seq[1] = 8'h02; seq[2] = 8'h40;
        in_valid = 1; in_sel = 1; in_hold = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            in_valid = (k == 1);
            in_sel = 6; in_hold = 0;
            vectors++;
            if (act !== exp_v || out_onehot !== seq[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d] act=%h exp=%h", k, act, exp_v);
            end
        end
        tick();
        vectors++;
        if (act !== exp_v || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_out_of_range();
        logic [9:0] a6;
        v6 = 1; s6 = 7; h6 = 0;
        @(posedge clk); #1;
        v6 = 0;
        a6 = {e6, b6, ov6, r6, o6};
        vectors++;
        if (a6 !== {4'b1001, 6'h00}) begin
            errors++;
            $display("FAIL oor_err act=%h exp=%h", a6, {4'b1001, 6'h00});
        end
        @(posedge clk); #1;
        vectors++;
        if (e6 !== 1'b0) begin
            errors++;
            $display("FAIL oor_pulse act=%b exp=0", e6);
        end
        v6 = 1; s6 = 2; h6 = 0;
        @(posedge clk); #1;
        s6 = 6;
        vectors++;
        if (o6 !== 6'h04 || r6 !== 1'b1 || e6 !== 1'b0) begin
            errors++;
            $display("FAIL oor_valid act=%h exp=04", o6);
        end
        @(posedge clk); #1;
        v6 = 0;
        a6 = {e6, b6, ov6, r6, o6};
        vectors++;
        if (a6 !== {4'b1001, 6'h00}) begin
            errors++;
            $display("FAIL oor_active act=%h exp=%h", a6, {4'b1001, 6'h00});
        end
        v6 = 1; s6 = 5; h6 = 0;
        @(posedge clk); #1;
        v6 = 0;
        vectors++;
        if (o6 !== 6'h20 || e6 !== 1'b0) begin
            errors++;
            $display("FAIL oor_top act=%h exp=20", o6);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_sel = 0; in_hold = 15;
        for (int k = 0; k < 4; k++) begin
            tick();
            in_valid = 0;
            vectors++;
            if (act !== exp_v || out_onehot !== 8'h01) begin
                errors++;
                $display("FAIL mid[%0d] act=%h exp=%h", k, act, exp_v);
            end
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        vectors++;
        if (act !== exp_v || act !== 12'h800) begin
            errors++;
            $display("FAIL mid_reset act=%h exp=%h", act, exp_v);
        end
        in_valid = 1; in_sel = 3; in_hold = 0;
        tick();
        in_valid = 0;
        vectors++;
        if (act !== exp_v || out_onehot !== 8'h08) begin
            errors++;
            $display("FAIL mid_after act=%h exp=%h", act, exp_v);
        end
        tick();
    endtask

`ifdef DEC_THERMO_EN
    task automatic test_thermo();
        in_valid = 1; in_sel = 3; in_hold = 0; therm_mode = 1;
        tick();
        therm_mode = 0;
        vectors++;
        if (act !== exp_v || out_onehot !== 8'h0F) begin
            errors++;
            $display("FAIL thermo act=%h exp=%h", act, exp_v);
        end
        tick();
        in_valid = 0;
        vectors++;
        if (act !== exp_v || out_onehot !== 8'h08) begin
            errors++;
            $display("FAIL thermo_off act=%h exp=%h", act, exp_v);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 3'($urandom);
            in_hold  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            rst_n    = ($urandom_range(0, 60) != 0);
`ifdef DEC_THERMO_EN
            therm_mode = 1'($urandom);
`endif
            tick();
            vectors++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL rand[%0d] act=%h exp=%h", n, act, exp_v);
            end
            if (!therm_mode && $countones(out_onehot) > 1) begin
                errors++;
                $display("FAIL rand_onehot[%0d] act=%h exp=<=1 bit", n, out_onehot);
            end
        end
        rst_n = 1; in_valid = 0; therm_mode = 0;
    endtask

    initial begin
        m_left = 0; m_val = 0; m_err = 0;
        therm_mode = 0;
        v6 = 0; s6 = 0; h6 = 0;
        rst_n = 0; in_valid = 0; in_sel = 0; in_hold = 0;
        #1;
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef DEC_THERMO_EN
        test_thermo();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
